// File: rtl/audio_pkg.sv
// Shared widths, the stereo sample record and the 16-bit saturation helper
// for the audio rate decimator.
package audio_pkg;

  localparam int SUM_W = 27;
  localparam int CNT_W = 11;
  localparam int SMP_W = 16;

  typedef struct packed {
    logic signed [SMP_W-1:0] l;
    logic signed [SMP_W-1:0] r;
  } stereo_smp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_PUSH = 2'd2
  } dec_state_t;

  // Clamp a signed quotient (one bit wider than the sum) to the 16-bit range.
  function automatic logic signed [SMP_W-1:0] sat16(input logic signed [SUM_W:0] v);
    logic signed [SUM_W:0] hi;
    logic signed [SUM_W:0] lo;
    hi = (SUM_W+1)'(32767);
    lo = -(SUM_W+1)'(32768);
    if (v > hi)
      return 16'sh7FFF;
    else if (v < lo)
      return 16'sh8000;
    else
      return $signed(v[SMP_W-1:0]);
  endfunction

endpackage

// File: rtl/audio_sdiv.sv
// Serial signed restoring divider: one quotient bit per clock on magnitudes,
// sign reapplied and saturated at the output.
module audio_sdiv
  import audio_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0]        divisor,
  output logic                    busy,
  output logic                    done,
  output logic signed [SMP_W-1:0] quotient
);

  localparam int STEPS = SUM_W;
  localparam int CW    = $clog2(STEPS);

  logic [SUM_W-1:0] dvd_reg;
  logic [SUM_W-1:0] quo_reg;
  logic [CNT_W-1:0] rem_reg;
  logic [CNT_W-1:0] dvs_reg;
  logic [CW-1:0]    cnt_reg;
  logic             neg_reg;
  logic             busy_reg;

  logic [CNT_W:0]   trial;
  logic [CNT_W:0]   trial_sub;
  logic             fits;
  logic signed [SUM_W:0] quo_mag;

  assign trial     = {rem_reg, dvd_reg[SUM_W-1]};
  assign trial_sub = trial - {1'b0, dvs_reg};
  assign fits      = (trial >= {1'b0, dvs_reg});

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_reg  <= '0;
      quo_reg  <= '0;
      rem_reg  <= '0;
      dvs_reg  <= '0;
      cnt_reg  <= '0;
      neg_reg  <= 1'b0;
      busy_reg <= 1'b0;
    end else if (start && !busy_reg) begin
      // Negating the most negative sum still yields the right unsigned magnitude.
      neg_reg  <= dividend[SUM_W-1];
      dvd_reg  <= dividend[SUM_W-1] ? SUM_W'(-dividend) : SUM_W'(dividend);
      dvs_reg  <= divisor;
      quo_reg  <= '0;
      rem_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      dvd_reg <= {dvd_reg[SUM_W-2:0], 1'b0};
      rem_reg <= fits ? trial_sub[CNT_W-1:0] : trial[CNT_W-1:0];
      quo_reg <= {quo_reg[SUM_W-2:0], fits};
      cnt_reg <= cnt_reg + CW'(1);
      if (cnt_reg == CW'(STEPS-1))
        busy_reg <= 1'b0;
    end
  end

  // done marks the final step; the quotient is valid from the next cycle on.
  assign busy     = busy_reg;
  assign done     = busy_reg && (cnt_reg == CW'(STEPS-1));
  assign quo_mag  = $signed({1'b0, quo_reg});
  assign quotient = sat16(neg_reg ? -quo_mag : quo_mag);

endmodule

// File: rtl/audio_rate_decimator.sv
// Box-averaging decimator: accumulates stereo samples between phase-accumulator
// ticks, divides by the sample count and queues results in a FWFT FIFO.
module audio_rate_decimator
  import audio_pkg::*;
#(
  parameter int CLK_RATE   = 53693175,
  parameter int OUT_RATE   = 48000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic signed [SMP_W-1:0]       in_l,
  input  logic signed [SMP_W-1:0]       in_r,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [SMP_W-1:0]       out_l,
  output logic signed [SMP_W-1:0]       out_r,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PW = $clog2(CLK_RATE) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [PW-1:0] phase_reg;
  logic [PW-1:0] phase_sum;
  logic          tick;

  logic signed [SUM_W-1:0] sum_l_reg, sum_r_reg;
  logic signed [SUM_W-1:0] sum_l_next, sum_r_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;

  dec_state_t state_reg;
  logic       overflow_reg;
  logic       div_start;

  logic signed [SUM_W-1:0] div_dvd [2];
  logic signed [SMP_W-1:0] div_q   [2];
  logic [1:0]              div_busy;
  logic [1:0]              div_done;

  stereo_smp_t     fifo_mem [FIFO_DEPTH];
  stereo_smp_t     fifo_head;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     level_reg;
  logic            fifo_full;
  logic            push;
  logic            pop;

  // Phase accumulator and window sums
  assign phase_sum = phase_reg + PW'(OUT_RATE);
  assign tick      = en && (phase_sum >= PW'(CLK_RATE));

  always_ff @(posedge clk) begin
    if (reset || !en)
      phase_reg <= '0;
    else if (tick)
      phase_reg <= phase_sum - PW'(CLK_RATE);
    else
      phase_reg <= phase_sum;
  end

  // The tick cycle's sample is folded into the snapshot via the *_next values.
  assign sum_l_next = sum_l_reg + SUM_W'(in_l);
  assign sum_r_next = sum_r_reg + SUM_W'(in_r);
  assign cnt_next   = cnt_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset || !en || tick) begin
      sum_l_reg <= '0;
      sum_r_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      sum_l_reg <= sum_l_next;
      sum_r_reg <= sum_r_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Dividers latch the snapshot on start
  assign div_start  = tick && (state_reg == ST_IDLE) && !(|div_busy);
  assign div_dvd[0] = sum_l_next;
  assign div_dvd[1] = sum_r_next;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_div
      audio_sdiv u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_dvd[gi]),
        .divisor  (cnt_next),
        .busy     (div_busy[gi]),
        .done     (div_done[gi]),
        .quotient (div_q[gi])
      );
    end
  endgenerate

  // Control FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= (tick && (state_reg != ST_IDLE)) ||
                      ((state_reg == ST_PUSH) && !push);
      case (state_reg)
        ST_IDLE: if (div_start) state_reg <= ST_DIV;
        ST_DIV:  if (&div_done) state_reg <= ST_PUSH;
        ST_PUSH: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // First-word fall-through FIFO
  assign fifo_full = (level_reg == (AW+1)'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;
  assign push      = (state_reg == ST_PUSH) && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= '{l: div_q[0], r: div_q[1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push && !pop)
        level_reg <= level_reg + (AW+1)'(1);
      else if (pop && !push)
        level_reg <= level_reg - (AW+1)'(1);
    end
  end

  assign fifo_head = fifo_mem[rd_ptr_reg];
  assign out_valid = (level_reg != '0);
  assign out_l     = out_valid ? fifo_head.l : '0;
  assign out_r     = out_valid ? fifo_head.r : '0;
  assign overflow  = overflow_reg;
  assign level     = level_reg;

endmodule

// File: tb/tb_audio_rate_decimator.sv
// Directed bench for audio_rate_decimator with CLK_RATE=100, OUT_RATE=3:
// ticks land on window cycles 33, 66, 99 of every 100 enabled clocks.
module tb_audio_rate_decimator;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               en = 1'b0;
  logic signed [15:0] in_l = '0;
  logic signed [15:0] in_r = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [15:0] out_l;
  logic signed [15:0] out_r;
  logic               overflow;
  logic [3:0]         level;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] pop_l[$];
  logic [15:0] pop_r[$];
  int          ovf_cnt = 0;

  int          k = 0;
  int          mode = 0;
  logic [15:0] cl = '0;
  logic [15:0] cr = '0;

  audio_rate_decimator #(
    .CLK_RATE   (100),
    .OUT_RATE   (3),
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_l      (in_l),
    .in_r      (in_r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_l     (out_l),
    .out_r     (out_r),
    .overflow  (overflow),
    .level     (level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      pop_l.push_back(out_l);
      pop_r.push_back(out_r);
      $display("pop  t=%0t l=%04h r=%04h level=%0d", $time, out_l, out_r, level);
    end
    if (overflow) begin
      ovf_cnt++;
      $display("ovf  t=%0t level=%0d", $time, level);
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  // mode 0: constant cl/cr; 1: +/-1000 alternating; 2: 100*(window+1) per window
  task automatic run(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0: begin in_l = cl; in_r = cr; end
        1: begin
          in_l = (k % 2 == 0) ? 16'sd1000 : -16'sd1000;
          in_r = -in_l;
        end
        default: begin
          w = (k / 100) * 3 + ((k % 100) >= 34 ? 1 : 0) + ((k % 100) >= 67 ? 1 : 0);
          in_l = 16'(100 * (w + 1));
          in_r = -in_l;
        end
      endcase
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    k     = 0;
  endtask

  initial begin
    int base;
    int ovf_base;
    int alt_l [6];

    // Reset state
    do_reset();
    check("rst_valid", 16'(out_valid), 16'd0);
    check("rst_l", out_l, 16'h0000);
    check("rst_r", out_r, 16'h0000);
    check("rst_ovf", 16'(overflow), 16'd0);
    check("rst_level", 16'(level), 16'd0);

    // Constant input: latency tick+29, then 90 windows per 3000 enabled clocks
    mode = 0; cl = 16'h1234; cr = 16'hF000; en = 1'b1;
    base = pop_l.size();
    ovf_base = ovf_cnt;
    run(61);
    check("lat_before", 16'(out_valid), 16'd0);
    run(1);
    check("lat_at", 16'(out_valid), 16'd1);
    check("lat_l", out_l, 16'h1234);
    run(2938);
    en = 1'b0;
    run(40);
    check("const_pops", 16'(pop_l.size() - base), 16'd90);
    for (int i = 0; i < 90 && base + i < pop_l.size(); i++) begin
      check("const_l", pop_l[base+i], 16'h1234);
      check("const_r", pop_r[base+i], 16'hF000);
    end
    check("const_ovf", 16'(ovf_cnt - ovf_base), 16'd0);
    check("const_level", 16'(level), 16'd0);

    // Full-scale extremes average back exactly
    do_reset();
    cl = 16'h8000; cr = 16'h7FFF; en = 1'b1;
    base = pop_l.size();
    run(34);
    en = 1'b0;
    run(35);
    check("ext_pops", 16'(pop_l.size() - base), 16'd1);
    if (pop_l.size() > base) begin
      check("ext_neg", pop_l[base], 16'h8000);
      check("ext_pos", pop_r[base], 16'h7FFF);
    end

    // Backpressure: 10 windows into an 8-deep FIFO
    do_reset();
    mode = 2; out_ready = 1'b0; en = 1'b1;
    ovf_base = ovf_cnt;
    base = pop_l.size();
    run(340);
    en = 1'b0;
    run(40);
    check("bp_level", 16'(level), 16'd8);
    check("bp_ovf", 16'(ovf_cnt - ovf_base), 16'd2);
    check("bp_head", out_l, 16'd100);
    out_ready = 1'b1;
    run(12);
    check("bp_pops", 16'(pop_l.size() - base), 16'd8);
    for (int i = 0; i < 8 && base + i < pop_l.size(); i++) begin
      check("bp_order_l", pop_l[base+i], 16'(100 * (i + 1)));
      check("bp_order_r", pop_r[base+i], 16'(-100 * (i + 1)));
    end
    check("bp_empty_level", 16'(level), 16'd0);
    check("bp_empty_valid", 16'(out_valid), 16'd0);
    check("bp_empty_l", out_l, 16'h0000);
    check("bp_empty_r", out_r, 16'h0000);

    // Reset while dividing abandons the result
    do_reset();
    mode = 0; cl = 16'd500; cr = -16'sd500; en = 1'b1;
    base = pop_l.size();
    run(40);
    reset = 1'b1; cl = 16'd700; cr = -16'sd700;
    run(1);
    reset = 1'b0;
    k = 0;
    run(55);
    check("rdiv_novalid", 16'(out_valid), 16'd0);
    check("rdiv_nopop", 16'(pop_l.size() - base), 16'd0);
    run(7);
    check("rdiv_valid", 16'(out_valid), 16'd1);
    check("rdiv_l", out_l, 16'd700);
    en = 1'b0;
    run(40);
    check("rdiv_pops", 16'(pop_l.size() - base), 16'd1);
    if (pop_r.size() > base)
      check("rdiv_r", pop_r[base], 16'(-700));

    // en low mid-window: no ticks, next window only sees post-enable samples
    do_reset();
    cl = 16'd200; cr = -16'sd200; en = 1'b1;
    base = pop_l.size();
    run(20);
    en = 1'b0; cl = 16'h7FFF; cr = 16'h7FFF;
    run(500);
    check("enlow_pops", 16'(pop_l.size() - base), 16'd0);
    check("enlow_level", 16'(level), 16'd0);
    en = 1'b1; cl = 16'd300; cr = -16'sd300; k = 0;
    run(34);
    en = 1'b0;
    run(35);
    check("enlow_after_pops", 16'(pop_l.size() - base), 16'd1);
    if (pop_l.size() > base) begin
      check("enlow_l", pop_l[base], 16'd300);
      check("enlow_r", pop_r[base], 16'(-300));
    end

    // Alternating +/-1000: even windows cancel, odd-length ones leave +/-1000/33
    do_reset();
    mode = 1; en = 1'b1;
    base = pop_l.size();
    run(200);
    en = 1'b0;
    run(40);
    alt_l = '{0, 30, -30, 0, 30, -30};
    check("alt_pops", 16'(pop_l.size() - base), 16'd6);
    for (int i = 0; i < 6 && base + i < pop_l.size(); i++) begin
      check("alt_l", pop_l[base+i], 16'(alt_l[i]));
      check("alt_r", pop_r[base+i], 16'(-alt_l[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
